// File: rtl/board_access_arbiter_pkg.sv
// Shared board geometry, cell encodings and address helpers for the board
// access arbiter and its store.
package board_access_arbiter_pkg;

  localparam int ROWS   = 6;
  localparam int COLS   = 7;
  localparam int CELL_W = 2;
  localparam int CELLS  = ROWS * COLS;
  localparam int ADDR_W = 6;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [CELL_W-1:0] cell_t;

  typedef enum logic [CELL_W-1:0] {
    EMPTY = 2'd0,
    P1    = 2'd1,
    P2    = 2'd2,
    RSVD  = 2'd3
  } cell_e;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam addr_t LAST_ADDR = addr_t'(CELLS - 1);

  function automatic addr_t cell_addr(logic [2:0] row, logic [2:0] col);
    return addr_t'(row) * addr_t'(COLS) + addr_t'(col);
  endfunction

  // row/col can alias a valid linear address (e.g. col 7), so range is
  // judged on the coordinates, not on the address.
  function automatic logic in_range(logic [2:0] row, logic [2:0] col);
    return (row < 3'(ROWS)) && (col < 3'(COLS));
  endfunction

endpackage

// File: rtl/board_access_arbiter_if.sv
// Request/response bundle between the renderer, game logic, clear
// requester (master) and the board access arbiter (slave).
interface board_access_arbiter_if;
  import board_access_arbiter_pkg::*;

  logic       vblank;
  logic       vid_req;
  logic [2:0] vid_row;
  logic [2:0] vid_col;
  cell_t      vid_data;
  logic       vid_valid;
  logic       wr_req;
  logic [2:0] wr_row;
  logic [2:0] wr_col;
  cell_t      wr_data;
  logic       wr_ack;
  logic       clr_req;
  logic       clr_busy;

  modport master (
    output vblank, vid_req, vid_row, vid_col,
    output wr_req, wr_row, wr_col, wr_data, clr_req,
    input  vid_data, vid_valid, wr_ack, clr_busy
  );

  modport slave (
    input  vblank, vid_req, vid_row, vid_col,
    input  wr_req, wr_row, wr_col, wr_data, clr_req,
    output vid_data, vid_valid, wr_ack, clr_busy
  );

endinterface

// File: rtl/board_access_arbiter_store.sv
// Single-port ROWS*COLS cell register array with registered read data.
module board_store
  import board_access_arbiter_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  addr_t addr,
  input  logic  re,
  input  logic  we,
  input  cell_t wdata,
  output cell_t rdata
);

  logic [CELLS-1:0][CELL_W-1:0] cells;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cells <= '0;
      rdata <= '0;
    end else begin
      if (we && addr <= LAST_ADDR) cells[addr] <= wdata;
      if (re) rdata <= (addr <= LAST_ADDR) ? cells[addr] : '0;
    end
  end

endmodule

// File: rtl/board_access_arbiter.sv
// Arbitrates the board store between video reads, a whole-board clear sweep
// and game-logic writes; changes land only in vertical blanking.
module board_access_arbiter
  import board_access_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  board_access_arbiter_if.slave bus
);

  state_t state;
  addr_t  clr_addr;
  logic   clr_busy_q, wr_ack_q, vid_valid_q, vid_oor;

  addr_t  st_addr;
  logic   st_we;
  cell_t  st_wdata, st_rdata;

  logic   vid_in, wr_in, clr_step, wr_grant;

  assign vid_in   = in_range(bus.vid_row, bus.vid_col);
  assign wr_in    = in_range(bus.wr_row, bus.wr_col);
  assign clr_step = (state == CLEAR) && bus.vblank && !bus.vid_req;
  // Blocking on wr_ack_q stops a still-held wr_req from writing twice.
  assign wr_grant = bus.wr_req && (state == IDLE) && !bus.clr_req &&
                    bus.vblank && !bus.vid_req && !wr_ack_q;

  always_comb begin
    st_addr  = cell_addr(bus.wr_row, bus.wr_col);
    st_we    = 1'b0;
    st_wdata = bus.wr_data;
    if (bus.vid_req) begin
      st_addr = cell_addr(bus.vid_row, bus.vid_col);
    end else if (clr_step) begin
      st_addr  = clr_addr;
      st_we    = 1'b1;
      st_wdata = cell_t'(EMPTY);
    end else if (wr_grant) begin
      st_we = wr_in;
    end
  end

  board_store u_store (
    .clk   (clk),
    .reset (reset),
    .addr  (st_addr),
    .re    (bus.vid_req),
    .we    (st_we),
    .wdata (st_wdata),
    .rdata (st_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      clr_addr    <= '0;
      clr_busy_q  <= 1'b0;
      wr_ack_q    <= 1'b0;
      vid_valid_q <= 1'b0;
      vid_oor     <= 1'b0;
    end else begin
      vid_valid_q <= bus.vid_req;
      if (bus.vid_req) vid_oor <= !vid_in;
      wr_ack_q <= wr_grant;
      case (state)
        IDLE: begin
          if (bus.clr_req) begin
            state      <= CLEAR;
            clr_busy_q <= 1'b1;
            clr_addr   <= '0;
          end
        end
        CLEAR: begin
          if (clr_step) begin
            if (clr_addr == LAST_ADDR) begin
              state      <= IDLE;
              clr_busy_q <= 1'b0;
              clr_addr   <= '0;
            end else begin
              clr_addr <= clr_addr + addr_t'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Held out-of-range flag keeps vid_data at 0 after an out-of-range read.
  assign bus.vid_data  = vid_oor ? cell_t'(EMPTY) : st_rdata;
  assign bus.vid_valid = vid_valid_q;
  assign bus.wr_ack    = wr_ack_q;
  assign bus.clr_busy  = clr_busy_q;

endmodule
